// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the MIPS HI/LO registers.
// Optional MADD/MSUB accumulate support is enabled by defining MULDIV_MADD_EN.
module muldiv_unit #(
    parameter int MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] srca,
    input  logic [31:0] srcb,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef MULDIV_MADD_EN
    localparam logic [2:0] OP_MSUB  = 3'b111;
`endif

    localparam int CW = ($clog2(MUL_LAT + 1) > 5) ? $clog2(MUL_LAT + 1) : 5;
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(31);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic [2:0]    op_r;
    logic [31:0]   a_r, b_r;
    logic [31:0]   rem_r, quo_r;
    logic          neg_q, neg_r, dbz;

    logic          is_mul, is_div, is_mt, is_mac, accept;
    logic [63:0]   prod, mul_res;
    logic [32:0]   rem_sh, diff;
    logic [31:0]   a_mag, b_mag, q_fix, r_fix;
    logic          signed_op;

    always_comb begin
        is_mul = (op == OP_MULT) || (op == OP_MULTU);
        is_div = (op == OP_DIV) || (op == OP_DIVU);
        is_mt  = (op == OP_MTHI) || (op == OP_MTLO);
`ifdef MULDIV_MADD_EN
        is_mac = (op[2:1] == 2'b11);
`else
        is_mac = 1'b0;
`endif
        accept = (state == IDLE) && start && !flush && (is_mul || is_div || is_mt || is_mac);
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept) begin
                if (is_mul || is_mac)
                    state_n = MUL;
                else if (is_div)
                    state_n = (srcb == '0) ? FIX : DIV;
            end
            MUL:  if (cnt == '0) state_n = IDLE;
            DIV:  if (cnt == DIV_LAST) state_n = FIX;
            FIX:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (flush)
            state_n = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    assign busy = (state != IDLE);

    // Divider magnitudes are taken at acceptance so the iteration is unsigned.
    always_comb begin
        signed_op = (op == OP_DIV);
        a_mag     = (signed_op && srca[31]) ? -srca : srca;
        b_mag     = (signed_op && srcb[31]) ? -srcb : srcb;
    end

    always_comb begin
        rem_sh = {rem_r, quo_r[31]};
        diff   = rem_sh - {1'b0, b_r};
        q_fix  = neg_q ? -quo_r : quo_r;
        r_fix  = neg_r ? -rem_r : rem_r;
    end

    // Low 64 bits of the extended product are exact for both signed and unsigned.
    always_comb begin
        if (op_r == OP_MULTU)
            prod = {32'b0, a_r} * {32'b0, b_r};
        else
            prod = {{32{a_r[31]}}, a_r} * {{32{b_r[31]}}, b_r};
`ifdef MULDIV_MADD_EN
        if (op_r[2:1] == 2'b11)
            mul_res = (op_r == OP_MSUB) ? ({hi, lo} - prod) : ({hi, lo} + prod);
        else
            mul_res = prod;
`else
        mul_res = prod;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
            cnt   <= '0;
            op_r  <= '0;
            a_r   <= '0;
            b_r   <= '0;
            rem_r <= '0;
            quo_r <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dbz   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    op_r <= op;
                    a_r  <= srca;
                    b_r  <= srcb;
                    if (op == OP_MTHI)
                        hi <= srca;
                    else if (op == OP_MTLO)
                        lo <= srca;
                    else if (is_div) begin
                        b_r   <= b_mag;
                        quo_r <= a_mag;
                        rem_r <= '0;
                        cnt   <= '0;
                        neg_q <= signed_op && (srca[31] ^ srcb[31]);
                        neg_r <= signed_op && srca[31];
                        dbz   <= (srcb == '0);
                    end else
                        cnt <= MUL_LAST;
                end
                MUL: begin
                    if (cnt == '0) begin
                        if (!flush) begin
                            hi   <= mul_res[63:32];
                            lo   <= mul_res[31:0];
                            done <= 1'b1;
                        end
                    end else
                        cnt <= cnt - 1'b1;
                end
                DIV: begin
                    if (!diff[32]) begin
                        rem_r <= diff[31:0];
                        quo_r <= {quo_r[30:0], 1'b1};
                    end else begin
                        rem_r <= rem_sh[31:0];
                        quo_r <= {quo_r[30:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                end
                FIX: if (!flush) begin
                    hi   <= dbz ? a_r : r_fix;
                    lo   <= dbz ? '1 : q_fix;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors, results checked on each done pulse.
// Define MULDIV_MADD_EN for both files to exercise the accumulate ops.
module tb_muldiv_unit;

    localparam logic [2:0] MULT  = 3'b000;
    localparam logic [2:0] MULTU = 3'b001;
    localparam logic [2:0] DIV   = 3'b010;
    localparam logic [2:0] DIVU  = 3'b011;
    localparam logic [2:0] MTHI  = 3'b100;
    localparam logic [2:0] MTLO  = 3'b101;
    localparam logic [2:0] MADD  = 3'b110;
`ifdef MULDIV_MADD_EN
    localparam logic [2:0] MSUB  = 3'b111;
`endif

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  op;
    logic [31:0] srca, srcb;
    logic        busy, done;
    logic [31:0] hi, lo;

    int          vectors = 0;
    int          miscompares = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    muldiv_unit #(.MUL_LAT(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .srca  (srca),
        .srcb  (srcb),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk)
        if (!rst && start && busy)
            $error("start issued while busy");

    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got done with hi/lo %h_%h, expected no done", hi, lo);
            end else
                check("result_hilo", {hi, lo}, exp_q.pop_front());
        end
    end

    // Called at a falling edge; returns at the falling edge of the first busy cycle.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        srca  = a;
        srcb  = b;
        @(negedge clk);
        start = 1'b0;
        srca  = 32'hDEAD_BEEF;
        srcb  = 32'h0BAD_F00D;
    endtask

    task automatic wait_idle(input string name, input int exp_cycles);
        int n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        check(name, 64'(n), 64'(exp_cycles));
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int cycles, input logic [63:0] exp);
        exp_q.push_back(exp);
        issue(o, a, b);
        wait_idle(name, cycles);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; srca = '0; srcb = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_hilo", {hi, lo}, 64'h0);
        check("reset_busy_done", {62'b0, busy, done}, 64'h0);

        run_op("mult_busy",  MULT,  32'hFFFF_FFFF, 32'h2, 3, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("multu_busy", MULTU, 32'hFFFF_FFFF, 32'h2, 3, 64'h0000_0001_FFFF_FFFE);
        run_op("div_busy",   DIV,   32'hFFFF_FFF9, 32'h2, 33, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu0_busy", DIVU,  32'h0000_1234, 32'h0, 1, 64'h0000_1234_FFFF_FFFF);
        run_op("div0_busy",  DIV,   32'h8000_0000, 32'h0, 1, 64'h8000_0000_FFFF_FFFF);
        run_op("divmin_busy", DIV,  32'h8000_0000, 32'hFFFF_FFFF, 33, 64'h0000_0000_8000_0000);
        run_op("divu_busy",  DIVU,  32'd100, 32'd7, 33, 64'h0000_0002_0000_000E);
        run_op("divneg_busy", DIV,  32'd7, 32'hFFFF_FFFE, 33, 64'h0000_0001_FFFF_FFFD);

        // Back-to-back: second start lands in the done cycle of the first.
        run_op("b2b_first",  MULT,  32'd3, 32'd4, 3, 64'h0000_0000_0000_000C);
        run_op("b2b_second", MULTU, 32'd5, 32'd6, 3, 64'h0000_0000_0000_001E);

        issue(MTHI, 32'h0000_AAAA, 32'h0);
        check("mthi", {32'b0, hi, 31'b0, busy}, {32'b0, 32'h0000_AAAA, 32'b0});
        issue(MTLO, 32'h0000_BBBB, 32'h0);
        check("mtlo", {32'b0, lo, 31'b0, busy}, {32'b0, 32'h0000_BBBB, 32'b0});

        issue(DIV, 32'd100, 32'd3);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'h0);
        check("flush_hilo", {hi, lo}, 64'h0000_AAAA_0000_BBBB);
        issue(MTLO, 32'h5, 32'h0);
        check("mtlo_after_flush", {hi, lo}, 64'h0000_AAAA_0000_0005);

        flush = 1'b1;
        issue(MTHI, 32'h0000_1234, 32'h0);
        flush = 1'b0;
        check("flush_with_start", {hi, lo, 31'b0, busy}, {32'h0000_AAAA, 32'h0000_0005, 32'b0});

        issue(DIV, 32'd9, 32'd3);
        repeat (32) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_div_last", {hi, lo, 30'b0, busy, done}, {32'h0000_AAAA, 32'h0000_0005, 32'b0});

        issue(MULT, 32'd2, 32'd3);
        repeat (2) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_mul_last", {hi, lo, 30'b0, busy, done}, {32'h0000_AAAA, 32'h0000_0005, 32'b0});

        issue(MTHI, 32'h0, 32'h0);
        issue(MTLO, 32'hFFFF_FFFF, 32'h0);
`ifdef MULDIV_MADD_EN
        run_op("madd_busy", MADD, 32'd1, 32'd1, 3, 64'h0000_0001_0000_0000);
        run_op("msub_busy", MSUB, 32'd2, 32'd3, 3, 64'h0000_0000_FFFF_FFFA);
`else
        issue(MADD, 32'd1, 32'd1);
        check("madd_noop_busy", 64'(busy), 64'h0);
        @(negedge clk);
        check("madd_noop_hilo", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
`endif

        issue(DIV, 32'd100, 32'd3);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("reset_midop", {hi, lo, 31'b0, busy}, {64'h0, 32'b0});

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle multiply/divide unit that owns the architectural HI/LO registers of the MIPS core. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the execute stage and sequences an iterative radix-2 divider and a fixed-latency multiplier. It raises `busy` so the pipeline stalls dependent instructions, and it drives `hi`/`lo` into the ALU's MFHI/MFLO path.

## Interface
Parameters:
- `MUL_LAT`, 3: busy cycles for a multiply, minimum 1.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  issue strobe, sampled only when `busy`=0.
- `op`  in  3  encoding:
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU
  - 100 MTHI, 101 MTLO
  - 110 MADD, 111 MSUB
- `srca`  in  32  rs operand; dividend, or MTHI/MTLO source.
- `srcb`  in  32  rt operand; divisor.
- `flush`  in  1  abort the in-flight op (exception or ERET).
- `busy`  out  1  op in progress; the pipeline must stall MFHI/MFLO and new muldiv ops.
- `done`  out  1  one-cycle pulse in the first cycle HI/LO hold a new result.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States:
  - IDLE: waits for `start`.
  - MUL: counts `MUL_LAT` cycles.
  - DIV: 32 iterations, then a sign-fix cycle.
  - FIX: final correction and write.
- Operands are latched at acceptance; later changes to `srca`/`srcb` have no effect.
- MTHI/MTLO:
  - Write HI or LO at the accepting edge.
  - No busy cycle, no `done`.
- MULT/MULTU:
  - Compute the full 64-bit product, signed or unsigned.
  - {HI,LO} = product.
- DIV/DIVU:
  - Restoring division on magnitudes: 32 shift/subtract iterations, then FIX.
  - Signed: quotient negated if sign(srca)^sign(srcb); remainder takes the sign of srca.
  - 0x80000000 / 0xFFFFFFFF (signed) gives LO=0x80000000, HI=0.
  - LO = quotient, HI = remainder.
- Divide by zero:
  - Detected at acceptance; one busy cycle.
  - HI=srca, LO=0xFFFFFFFF, for both signed and unsigned.
- MADD/MSUB: {HI,LO} = {HI,LO} ± signed 64-bit product, modulo 2^64.
- Reset: HI=0, LO=0, `busy`=0, `done`=0, state IDLE.
- `start` while `busy`=1 is ignored. This is a pipeline protocol violation, and the bench asserts it never happens.

## Timing
- Reference edge E0 is the edge that samples `start`=1 with `busy`=0.
- MUL:
  - `busy`=1 for cycles E0..E(MUL_LAT).
  - HI/LO written at edge E(MUL_LAT).
  - In the cycle after that edge: `busy`=0, `done`=1.
- DIV (divisor non-zero):
  - `busy`=1 for 33 cycles.
  - HI/LO written at E33.
  - `busy`=0 and `done`=1 after E33.
- Divide by zero: HI/LO written at E1; `done`=1 after E1.
- MTHI/MTLO: new value visible in the cycle after E0; `busy` stays 0.
- `flush`:
  - When sampled, the next state is IDLE and `busy`=0 next cycle.
  - HI/LO are not written and no `done` is produced.
  - If `flush` and `start` arrive in the same cycle, `flush` wins and the op is discarded, including MTHI/MTLO.
  - A flush in the same cycle as the final write edge also suppresses the write.
- `rst` mid-operation: the op is discarded and HI/LO are cleared.
- Back-to-back: a new `start` is accepted in the same cycle that `done`=1.

## Configuration
- `MULDIV_MADD_EN` defined:
  - op 110/111 perform MADD/MSUB.
  - Latency equals `MUL_LAT`.
- Undefined:
  - op 110/111 are treated as no-ops: not accepted, `busy` stays 0, no `done`, HI/LO unchanged.
  - No accumulate adder is built.

## Test plan
- MULT with srca=0xFFFFFFFF, srcb=0x00000002, MUL_LAT=3 -> `busy` for 3 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE, `done` pulse.
- MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV with srca=0xFFFFFFF9 (-7), srcb=2 -> `busy` for 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU with srca=0x00001234, srcb=0 -> 1 busy cycle, then HI=0x00001234, LO=0xFFFFFFFF.
- DIV flushed on its 10th busy cycle -> `busy`=0 the next cycle, HI/LO unchanged, no `done`. An MTLO of 0x5 issued immediately after -> LO=0x5.
- With `MULDIV_MADD_EN`: preload HI=0, LO=0xFFFFFFFF, then MADD 1×1 -> HI=0x00000001, LO=0x00000000. Without the macro, the same op leaves HI/LO unchanged.
